// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the write-back port arbiter.
// Optional feature macro: WB_PERF_CNT_EN (adds a conflict counter output).
package wb_arb_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int ADDR_W_DEF     = 3;
  localparam int STARVE_MAX_DEF = 3;
  localparam int STARVE_CNT_W   = 4;

  // Which holding buffer drives the write-back port this cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } gnt_e;

  // One pending register-file write at the default widths
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding buffer with valid/ready capture and clear-on-grant.
// A capture on the same edge as a grant refills the buffer instead of clearing it.
module wb_hold_buf #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_entry,
  input  logic         grant,
  output logic         ready,
  output logic         occupied,
  output logic [W-1:0] entry
);

  logic         occ_q, occ_d;
  logic [W-1:0] entry_q, entry_d;

  // Ready depends only on buffer state and grant, never on in_valid
  always_comb begin
    ready    = !occ_q || grant;
    occupied = occ_q;
    entry    = entry_q;
  end

  // Next-state: capture takes priority over the clear caused by a grant
  always_comb begin
    occ_d   = occ_q;
    entry_d = entry_q;
    if (in_valid && ready) begin
      occ_d   = 1'b1;
      entry_d = in_entry;
    end else if (grant) begin
      occ_d = 1'b0;
    end
  end

  // Buffer state register, emptied by the asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q   <= 1'b0;
      entry_q <= '0;
    end else begin
      occ_q   <= occ_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: memory-first with ALU anti-starvation, registered wb_* output.
// Optional feature macro: WB_PERF_CNT_EN (adds 16-bit saturating conflict_cnt output).
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
`ifdef WB_PERF_CNT_EN
  output logic [15:0]       conflict_cnt,
`endif
  output logic              stall_req
);

  localparam int EW = ADDR_W + DATA_W;
  localparam logic [STARVE_CNT_W-1:0] StarveMax = STARVE_CNT_W'(STARVE_MAX);

  gnt_e                    gnt;
  logic                    aluOcc, memOcc;
  logic [EW-1:0]           aluEntry, memEntry;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic                    wbEn_q;
  logic [ADDR_W-1:0]       wbAddr_q;
  logic [DATA_W-1:0]       wbData_q;

  wb_hold_buf #(.W(EW)) u_alu_buf (
    .clk      (clk),
    .reset    (reset),
    .in_valid (alu_valid),
    .in_entry ({alu_rd, alu_data}),
    .grant    (gnt == GNT_ALU),
    .ready    (alu_ready),
    .occupied (aluOcc),
    .entry    (aluEntry)
  );

  wb_hold_buf #(.W(EW)) u_mem_buf (
    .clk      (clk),
    .reset    (reset),
    .in_valid (mem_valid),
    .in_entry ({mem_rd, mem_data}),
    .grant    (gnt == GNT_MEM),
    .ready    (mem_ready),
    .occupied (memOcc),
    .entry    (memEntry)
  );

  // Grant: memory wins contention unless the ALU has starved; equal rd always lets memory go first
  always_comb begin
    gnt = GNT_NONE;
    if (aluOcc && memOcc) begin
      if ((aluEntry[EW-1 -: ADDR_W] != memEntry[EW-1 -: ADDR_W]) && (starve_q == StarveMax))
        gnt = GNT_ALU;
      else
        gnt = GNT_MEM;
    end else if (aluOcc) begin
      gnt = GNT_ALU;
    end else if (memOcc) begin
      gnt = GNT_MEM;
    end
  end

  // Starvation count: saturating count of consecutive ALU losses, cleared otherwise
  always_comb begin
    starve_d = '0;
    if (aluOcc && (gnt != GNT_ALU))
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end

  // Write-back register: loads the granted entry, holds address/data when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbEn_q   <= 1'b0;
      wbAddr_q <= '0;
      wbData_q <= '0;
    end else begin
      wbEn_q <= (gnt != GNT_NONE);
      if (gnt == GNT_ALU) begin
        wbAddr_q <= aluEntry[EW-1 -: ADDR_W];
        wbData_q <= aluEntry[DATA_W-1:0];
      end else if (gnt == GNT_MEM) begin
        wbAddr_q <= memEntry[EW-1 -: ADDR_W];
        wbData_q <= memEntry[DATA_W-1:0];
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [15:0] conflict_q;

  // Conflict counter: saturating count of cycles with both buffers occupied
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                conflict_q <= '0;
    else if (aluOcc && memOcc && (conflict_q != 16'hFFFF)) conflict_q <= conflict_q + 16'd1;
  end

  assign conflict_cnt = conflict_q;
`endif

  // Drive registered outputs and the upstream stall
  always_comb begin
    wb_en     = wbEn_q;
    wb_addr   = wbAddr_q;
    wb_data   = wbData_q;
    stall_req = aluOcc && (gnt != GNT_ALU);
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed table, hand sequences and random traffic.
// Optional feature macro: WB_PERF_CNT_EN (enables conflict_cnt checks).
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int STARVE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid, mem_valid;
  logic       alu_ready, mem_ready;
  logic [2:0] alu_rd, mem_rd;
  logic [7:0] alu_data, mem_data;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       stall_req;
`ifdef WB_PERF_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  wb_port_arbiter #(.DATA_W(8), .ADDR_W(3), .STARVE_MAX(STARVE)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
`ifdef WB_PERF_CNT_EN
    .conflict_cnt (conflict_cnt),
`endif
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  // Reference model: each requester owns a pending slot, plus a loss streak for the ALU
  bit     aluPend, memPend;
  entry_t aluSlot, memSlot;
  int     aluLosses;
  bit     expWbEn;
  entry_t expWb;
  int     conflicts;

  typedef struct {
    bit         av;
    entry_t     a;
    bit         mv;
    entry_t     m;
    bit         wbEn;
    logic [2:0] wbAddr;
    logic [7:0] wbData;
  } vec_t;

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    aluPend = 0; memPend = 0; aluSlot = '0; memSlot = '0;
    aluLosses = 0; expWbEn = 0; expWb = '0; conflicts = 0;
  endtask

  // Who owns the port this cycle: 0 none, 1 ALU, 2 MEM
  function automatic int modelWinner();
    if (aluPend && memPend)
      return (aluSlot.rd != memSlot.rd && aluLosses >= STARVE) ? 1 : 2;
    if (aluPend) return 1;
    if (memPend) return 2;
    return 0;
  endfunction

  // One clock cycle: drive inputs, check handshake, advance model across the edge, check write-back
  task automatic applyStimulus(input bit av, input entry_t a, input bit mv, input entry_t m);
    int     w;
    bit     aRdy, mRdy;
    @(negedge clk);
    alu_valid = av; alu_rd = a.rd; alu_data = a.data;
    mem_valid = mv; mem_rd = m.rd; mem_data = m.data;
    #1;
    w    = modelWinner();
    aRdy = !aluPend || (w == 1);
    mRdy = !memPend || (w == 2);
    checkOutput("alu_ready", int'(alu_ready), int'(aRdy));
    checkOutput("mem_ready", int'(mem_ready), int'(mRdy));
    checkOutput("stall_req", int'(stall_req), int'(aluPend && w != 1));
    @(posedge clk);
    if (aluPend && memPend) conflicts++;
    expWbEn = (w != 0);
    if (w == 1) expWb = aluSlot;
    if (w == 2) expWb = memSlot;
    if (aluPend && w != 1) aluLosses = (aluLosses < STARVE) ? aluLosses + 1 : STARVE;
    else                   aluLosses = 0;
    if (w == 1) aluPend = 0;
    if (w == 2) memPend = 0;
    if (av && aRdy) begin aluPend = 1; aluSlot = a; end
    if (mv && mRdy) begin memPend = 1; memSlot = m; end
    #1;
    checkOutput("wb_en",   int'(wb_en),   int'(expWbEn));
    checkOutput("wb_addr", int'(wb_addr), int'(expWb.rd));
    checkOutput("wb_data", int'(wb_data), int'(expWb.data));
  endtask

  function automatic entry_t mk(input int rd, input int d);
    entry_t e;
    e.rd = 3'(rd); e.data = 8'(d);
    return e;
  endfunction

  vec_t vecs[14];

  initial begin
    // Directed sequence: single ALU stream, then sustained contention, then drain
    vecs[0]  = '{1, mk(3,8'h5A), 0, mk(0,0),    0, 3'd0, 8'h00};
    vecs[1]  = '{1, mk(4,8'h5B), 0, mk(0,0),    1, 3'd3, 8'h5A};
    vecs[2]  = '{1, mk(5,8'h5C), 0, mk(0,0),    1, 3'd4, 8'h5B};
    vecs[3]  = '{0, mk(0,0),     0, mk(0,0),    1, 3'd5, 8'h5C};
    vecs[4]  = '{0, mk(0,0),     0, mk(0,0),    0, 3'd5, 8'h5C};
    vecs[5]  = '{1, mk(1,8'hA0), 1, mk(6,8'hC0), 0, 3'd5, 8'h5C};
    vecs[6]  = '{1, mk(1,8'hA1), 1, mk(6,8'hC1), 1, 3'd6, 8'hC0};
    vecs[7]  = '{1, mk(1,8'hA2), 1, mk(6,8'hC2), 1, 3'd6, 8'hC1};
    vecs[8]  = '{1, mk(1,8'hA3), 1, mk(6,8'hC3), 1, 3'd6, 8'hC2};
    vecs[9]  = '{1, mk(1,8'hA4), 1, mk(6,8'hC4), 1, 3'd1, 8'hA0};
    vecs[10] = '{1, mk(1,8'hA5), 1, mk(6,8'hC5), 1, 3'd6, 8'hC3};
    vecs[11] = '{0, mk(0,0),     0, mk(0,0),    1, 3'd6, 8'hC5};
    vecs[12] = '{0, mk(0,0),     0, mk(0,0),    1, 3'd1, 8'hA4};
    vecs[13] = '{0, mk(0,0),     0, mk(0,0),    0, 3'd1, 8'hA4};

    // Reset with both requesters offering and the clock running
    reset = 1'b0;
    alu_valid = 1; alu_rd = 3'd7; alu_data = 8'hEE;
    mem_valid = 1; mem_rd = 3'd6; mem_data = 8'hDD;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_wb_en",     int'(wb_en),     0);
    checkOutput("rst_wb_addr",   int'(wb_addr),   0);
    checkOutput("rst_wb_data",   int'(wb_data),   0);
    checkOutput("rst_alu_ready", int'(alu_ready), 1);
    checkOutput("rst_mem_ready", int'(mem_ready), 1);
    checkOutput("rst_stall",     int'(stall_req), 0);
    @(negedge clk);
    alu_valid = 0; mem_valid = 0;
    reset = 1'b1;
    applyStimulus(0, '0, 0, '0);

    // Table-driven directed vectors
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].av, vecs[i].a, vecs[i].mv, vecs[i].m);
      checkOutput($sformatf("vec%0d_en", i),   int'(wb_en),   int'(vecs[i].wbEn));
      checkOutput($sformatf("vec%0d_addr", i), int'(wb_addr), int'(vecs[i].wbAddr));
      checkOutput($sformatf("vec%0d_data", i), int'(wb_data), int'(vecs[i].wbData));
    end

    // Same-rd collision: memory first, then the younger ALU value
    applyStimulus(1, mk(2,8'h11), 1, mk(2,8'h22));
    applyStimulus(0, '0, 0, '0);
    checkOutput("coll_first", int'(wb_data), 8'h22);
    applyStimulus(0, '0, 0, '0);
    checkOutput("coll_second", int'(wb_data), 8'h11);
    checkOutput("coll_addr", int'(wb_addr), 2);

`ifdef WB_PERF_CNT_EN
    // Five cycles with both buffers held full
    conflicts = 0;
    begin
      int before;
      before = int'(conflict_cnt);
      applyStimulus(1, mk(0,1), 1, mk(1,2));
      for (int i = 0; i < 5; i++) applyStimulus(1, mk(0,1), 1, mk(1,2));
      checkOutput("conflict_cnt", int'(conflict_cnt) - before, conflicts);
    end
`endif

    // Reset mid-operation with both buffers full
    applyStimulus(1, mk(4,8'h44), 1, mk(5,8'h55));
    @(negedge clk);
    alu_valid = 0; mem_valid = 0;
    reset = 1'b0;
    #1;
    checkOutput("midrst_wb_en",   int'(wb_en),   0);
    checkOutput("midrst_wb_data", int'(wb_data), 0);
    checkOutput("midrst_ready",   int'(alu_ready && mem_ready), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, '0, 0, '0);
      checkOutput("post_rst_idle", int'(wb_en), 0);
    end

    // Random traffic against the model; small rd range provokes collisions
    for (int i = 0; i < 400; i++) begin
      applyStimulus(bit'($urandom_range(0, 1)), mk($urandom_range(0, 3), $urandom),
                    bit'($urandom_range(0, 1)), mk($urandom_range(0, 3), $urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Sequences the single register-file write-back port of the 8-bit pipelined processor.
- Two requesters compete for the port:
  - ALU result stage, which produces one result per cycle.
  - Data-memory load return, which has variable latency.
- Each requester gets a one-entry holding buffer with a valid/ready handshake.
- Arbitration is memory-first with anti-starvation for the ALU; the granted write is registered onto wb_*, which also serves as the forwarding source.

Parameters:
- DATA_W, 8, write-back data width.
- ADDR_W, 3, destination register address width.
- STARVE_MAX, 3, consecutive ALU losses before the ALU is forced a grant; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU buffer can accept this cycle.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load data offered.
- mem_ready  out  1  memory buffer can accept this cycle.
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- wb_en  out  1  register-file write enable (registered).
- wb_addr  out  ADDR_W  write address (registered).
- wb_data  out  DATA_W  write data (registered); also the forwarding value.
- stall_req  out  1  upstream stall request.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both buffers are invalidated; pending data is dropped.
  - wb_en=0, wb_addr=0, wb_data=0, stall_req=0, starvation counter=0.
  - alu_ready=mem_ready=1 while reset is low and on release.
- Capture:
  - On a rising edge with x_valid && x_ready, the buffer loads {rd,data} and becomes occupied.
  - x_ready = buffer empty OR buffer granted this cycle. This depends only on buffer state, never on x_valid.
- Grant is combinational from buffer state each cycle:
  - Only one buffer occupied: grant it.
  - Both occupied, rd differs: grant MEM, unless starve_cnt==STARVE_MAX, in which case grant ALU.
  - Both occupied, rd equal: grant MEM regardless of counter. ALU is granted the following cycle, so the register ends with the ALU (younger) value.
  - Neither occupied: no grant.
- Output, on the edge after a grant:
  - wb_en=1, wb_addr/wb_data = granted entry.
  - Granted buffer clears on that same edge, unless refilled by a simultaneous capture.
  - No grant: wb_en=0; wb_addr/wb_data hold their previous values.
- Latency and throughput:
  - Capture edge N gives output at edge N+1 when uncontended.
  - Sustained 1 write/cycle from a single requester.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each edge where the ALU buffer is occupied and not granted.
  - Clears when the ALU is granted or its buffer is empty.
- stall_req = ALU buffer occupied AND not granted (alu_ready low).
- Reset asserted mid-operation: no write is issued for entries held at reset; after release the block behaves as freshly reset.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- Defined:
  - Adds output conflict_cnt, 16 bits.
  - Increments on each edge where both buffers are occupied; saturates at 0xFFFF.
  - Cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package wb_arb_pkg:
  - DATA_W/ADDR_W default constants.
  - Grant enum: GNT_NONE, GNT_ALU, GNT_MEM.
  - Entry struct {rd, data}.
- Sub-module wb_hold_buf: one-entry buffer with valid/ready, load, clear and refill-on-clear. Instantiated twice (ALU, MEM).
- Arbiter, starvation counter and output register live in the top level.

Test Plan:
- Reset:
  - Stimulus: reset=0 with both valids high and clk running.
  - Response: wb_en=0, wb_addr=0, wb_data=0, both ready=1, no capture. Asserting reset between edges zeroes the outputs immediately.
- Single ALU stream:
  - Stimulus: alu_valid=1 every cycle with rd=3/data=0x5A, then rd=4/0x5B, then rd=5/0x5C.
  - Response: wb_en=1 on three consecutive edges with matching addr/data one edge after each capture; alu_ready stays 1.
- Contention with STARVE_MAX=3:
  - Stimulus: both valid every cycle, distinct rd.
  - Response: grant pattern MEM,MEM,MEM,ALU repeating; stall_req=1 on the three MEM-granted cycles.
- Same-rd collision:
  - Stimulus: ALU rd=2/0x11 and MEM rd=2/0x22 captured on the same edge.
  - Response: wb writes 0x22 then 0x11 on consecutive edges.
- Reset mid-operation:
  - Stimulus: both buffers full, reset pulsed low between edges.
  - Response: no write of the held entries after release; wb_en stays 0 until a new capture.
- WB_PERF_CNT_EN:
  - Stimulus: 5 cycles with both buffers occupied.
  - Response: conflict_cnt=5. Preloaded at 0xFFFF, it stays 0xFFFF.
